mac_lane_accum: RTL
===================

// Module: mac_lane_accum
// PURPOSE
//  Multi-lane successor to the single-lane MAC accumulate stage of the matrix-multiply engine.
//  Accepts LANES products per beat (LANES adjacent C columns), accumulates each over K beats.
//  Emits finished C entries through a backpressured write port buffered by an output FIFO.
//  Sits between the multiplier stage and the matrix C memory; adds signed mode, valid/ready
//  handshaking, k-order checking and a restart input.
// PARAMETERS
//  M                        4               rows of A / C (>=2)
//  K                        4               inner dimension, beats per C entry (>=2)
//  N                        4               cols of B / C (>=2, N % LANES == 0)
//  LANES                    1               C columns processed per beat
//  DATA_WIDTH_INIT_MATRIX   32              A/B element width; product width = 2*DW
//  DATA_WIDTH_RESULT_MATRIX 2*DW+$clog2(K)  accumulator / C element width (RW)
//  SIGNED                   0               1: products and sums are two's complement, sign-extended
//  OUT_FIFO_DEPTH           2               output FIFO entries (power of 2, >=2)
// PORTS
//  clk                            in   1            clock, rising edge
//  resetn                         in   1            asynchronous active-low reset
//  clear                          in   1            synchronous restart: empties FIFO, clears state
//  product_reg                    in   LANES*2*DW   lane i product at [i*2DW +: 2DW]
//  product_valid                  in   1            product beat valid
//  product_ready                  out  1            beat accepted when valid && ready
//  matrix_a_row_addr_counter_reg  in   $clog2(M)    C row of this beat
//  matrix_a_col_addr_counter_reg  in   $clog2(K)    k index of this beat
//  matrix_b_col_addr_counter_reg  in   $clog2(N)    C column of lane 0
//  data_out_c                     out  LANES*RW     lane i result at [i*RW +: RW]
//  row_addr_c                     out  $clog2(M)    C row of data_out_c
//  col_addr_c                     out  $clog2(N)    C column of lane 0 of data_out_c
//  matrix_c_we                    out  1            write valid (FIFO non-empty)
//  matrix_c_ready                 in   1            C memory accepts write when we && ready
//  mac_done                       out  1            sticky: all M*N entries written
//  seq_err                        out  1            sticky: k index arrived out of order
// BEHAVIOUR
//  Reset (resetn=0, async): all outputs 0; acc=0, k_exp=0, out_cnt=0, FIFO empty, state ACCUM.
//  clear=1 gives the same state at the next edge; clear has priority over all other events.
//  FSM states:
//   ACCUM: product_ready = !fifo_full.
//     On each accepted beat:
//       k_exp==0: acc[i] <= ext(p[i]).
//       otherwise: acc[i] <= acc[i] + ext(p[i]).
//       ext = sign- or zero-extension to RW, per SIGNED.
//     When k_exp==K-1, in the same edge:
//       push {acc[i]+ext(p[i]), row in, col in} to the FIFO;
//       k_exp <= 0; out_cnt++.
//     Otherwise k_exp++.
//     Go to DRAIN when out_cnt reaches M*N/LANES.
//   DRAIN: product_ready=0; go to DONE when the FIFO is empty.
//   DONE: mac_done=1, product_ready=0; hold until clear or reset.
//  k check: if matrix_a_col_addr_counter_reg != k_exp on an accepted beat, set seq_err.
//   Accumulation still follows k_exp; seq_err clears only on clear or reset.
//  Output: data_out_c, row_addr_c and col_addr_c are the FIFO head.
//   Pop when matrix_c_we && matrix_c_ready.
//   Latency: beat accepted at edge t -> matrix_c_we=1 after edge t when the FIFO was empty.
//  Full FIFO: product_ready=0, so no beat is accepted. No same-cycle push-on-pop bypass.
//   Pushes and pops at the head in the same edge are both performed.
//  Width: RW bits hold K full-scale products, so no overflow occurs; the sum wraps at RW bits.
//  Beats with product_valid=1 while product_ready=0 are ignored, not latched.
//  Inputs are sampled only on accepted beats.
// TESTING
//  1. LANES=1, unsigned; row0/col0 products 28,18,25,16 at k=0..3, ready=1
//     -> one write: data_out_c=87, row=0, col=0.
//  2. Full 4x4x4 stream of 64 beats with matrix_c_ready=1
//     -> 16 writes in row/col order, then mac_done=1 one cycle after the last write.
//  3. Hold matrix_c_ready=0 for 3 entries, DEPTH=2
//     -> product_ready drops after the 2nd entry is pushed.
//     -> no data is lost; writes resume in order when ready=1.
//  4. SIGNED=1, products -5,3,-1,2 (2*DW-bit two's complement) -> data_out_c = -1 sign-extended to RW.
//  5. k sequence 0,2,1,3 -> seq_err=1 and sticky; the sum is still emitted after the 4th beat.
//  6. LANES=2; assert clear mid-entry and separately assert resetn=0 mid-entry
//     -> FIFO empty, outputs 0.
//     -> the next 4 beats form a fresh entry with a correct sum in each lane.

Source files
------------

// File: rtl/mac_lane_accum.sv
// Multi-lane MAC accumulate stage: sums LANES products over K beats per C entry and
// hands finished entries to the C memory through a small backpressured output FIFO.
module mac_lane_accum #(
  parameter int unsigned M                        = 4,
  parameter int unsigned K                        = 4,
  parameter int unsigned N                        = 4,
  parameter int unsigned LANES                    = 1,
  parameter int unsigned DATA_WIDTH_INIT_MATRIX   = 32,
  parameter int unsigned DATA_WIDTH_RESULT_MATRIX = 2 * DATA_WIDTH_INIT_MATRIX + $clog2(K),
  parameter bit          SIGNED                   = 1'b0,
  parameter int unsigned OUT_FIFO_DEPTH           = 2
) (
  input  logic                                      clk,
  input  logic                                      resetn,
  input  logic                                      clear,
  input  logic [LANES*2*DATA_WIDTH_INIT_MATRIX-1:0] product_reg,
  input  logic                                      product_valid,
  output logic                                      product_ready,
  input  logic [$clog2(M)-1:0]                      matrix_a_row_addr_counter_reg,
  input  logic [$clog2(K)-1:0]                      matrix_a_col_addr_counter_reg,
  input  logic [$clog2(N)-1:0]                      matrix_b_col_addr_counter_reg,
  output logic [LANES*DATA_WIDTH_RESULT_MATRIX-1:0] data_out_c,
  output logic [$clog2(M)-1:0]                      row_addr_c,
  output logic [$clog2(N)-1:0]                      col_addr_c,
  output logic                                      matrix_c_we,
  input  logic                                      matrix_c_ready,
  output logic                                      mac_done,
  output logic                                      seq_err
);

  localparam int unsigned PW    = 2 * DATA_WIDTH_INIT_MATRIX;
  localparam int unsigned RW    = DATA_WIDTH_RESULT_MATRIX;
  localparam int unsigned MW    = $clog2(M);
  localparam int unsigned KW    = $clog2(K);
  localparam int unsigned NW    = $clog2(N);
  localparam int unsigned DEPTH = OUT_FIFO_DEPTH;
  localparam int unsigned PTRW  = $clog2(DEPTH);
  localparam int unsigned CNTW  = PTRW + 1;
  localparam int unsigned TOTAL = M * N / LANES;
  localparam int unsigned CW    = $clog2(TOTAL + 1);
  localparam logic [KW-1:0] KLast = KW'(K - 1);

  typedef enum logic [1:0] {StAccum, StDrain, StDone} state_e;

  state_e                  state_q, state_d;
  logic [LANES*RW-1:0]     acc_q, acc_d, sum;
  logic [KW-1:0]           k_exp_q, k_exp_d;
  logic [CW-1:0]           out_cnt_q, out_cnt_d;
  logic                    seq_err_q, seq_err_d;
  logic                    mac_done_q, mac_done_d;
  logic [PTRW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0]         count_q, count_d;
  logic [LANES*RW-1:0]     data_mem_q [DEPTH];
  logic [LANES*RW-1:0]     data_mem_d [DEPTH];
  logic [MW-1:0]           row_mem_q  [DEPTH];
  logic [MW-1:0]           row_mem_d  [DEPTH];
  logic [NW-1:0]           col_mem_q  [DEPTH];
  logic [NW-1:0]           col_mem_d  [DEPTH];
  logic                    fifo_full, accept, last_beat, push, pop;

  assign fifo_full     = (count_q == CNTW'(DEPTH));
  assign product_ready = (state_q == StAccum) && !fifo_full;
  assign accept        = product_valid && product_ready;
  assign last_beat     = (k_exp_q == KLast);
  assign push          = accept && last_beat;
  assign matrix_c_we   = (count_q != '0);
  assign pop           = matrix_c_we && matrix_c_ready;

  assign data_out_c = data_mem_q[rd_ptr_q];
  assign row_addr_c = row_mem_q[rd_ptr_q];
  assign col_addr_c = col_mem_q[rd_ptr_q];
  assign mac_done   = mac_done_q;
  assign seq_err    = seq_err_q;

  // First beat of an entry starts from zero, so the sum doubles as the load value.
  always_comb begin
    sum = '0;
    for (int i = 0; i < LANES; i++) begin
      sum[i*RW +: RW] = ((k_exp_q == '0) ? {RW{1'b0}} : acc_q[i*RW +: RW]) +
                        {{(RW-PW){SIGNED && product_reg[i*PW+PW-1]}}, product_reg[i*PW +: PW]};
    end
  end

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    k_exp_d    = k_exp_q;
    seq_err_d  = seq_err_q;
    mac_done_d = mac_done_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    data_mem_d = data_mem_q;
    row_mem_d  = row_mem_q;
    col_mem_d  = col_mem_q;
    count_d    = count_q + CNTW'(push) - CNTW'(pop);
    out_cnt_d  = out_cnt_q + CW'(push);

    if (accept) begin
      acc_d   = sum;
      k_exp_d = last_beat ? '0 : k_exp_q + KW'(1);
      if (matrix_a_col_addr_counter_reg != k_exp_q) seq_err_d = 1'b1;
    end
    if (push) begin
      data_mem_d[wr_ptr_q] = sum;
      row_mem_d[wr_ptr_q]  = matrix_a_row_addr_counter_reg;
      col_mem_d[wr_ptr_q]  = matrix_b_col_addr_counter_reg;
      wr_ptr_d             = wr_ptr_q + PTRW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTRW'(1);

    case (state_q)
      StAccum: if (out_cnt_d == CW'(TOTAL)) state_d = StDrain;
      StDrain: begin
        // Finish as soon as the last entry leaves, not a cycle later.
        if (count_d == '0) begin
          state_d    = StDone;
          mac_done_d = 1'b1;
        end
      end
      default: state_d = StDone;
    endcase

    if (clear) begin
      state_d    = StAccum;
      acc_d      = '0;
      k_exp_d    = '0;
      seq_err_d  = 1'b0;
      mac_done_d = 1'b0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      out_cnt_d  = '0;
      data_mem_d = '{default: '0};
      row_mem_d  = '{default: '0};
      col_mem_d  = '{default: '0};
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= StAccum;
      acc_q      <= '0;
      k_exp_q    <= '0;
      seq_err_q  <= 1'b0;
      mac_done_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      out_cnt_q  <= '0;
      data_mem_q <= '{default: '0};
      row_mem_q  <= '{default: '0};
      col_mem_q  <= '{default: '0};
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      k_exp_q    <= k_exp_d;
      seq_err_q  <= seq_err_d;
      mac_done_q <= mac_done_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      out_cnt_q  <= out_cnt_d;
      data_mem_q <= data_mem_d;
      row_mem_q  <= row_mem_d;
      col_mem_q  <= col_mem_d;
    end
  end

endmodule
